// File: rtl/load_store_unit.sv
// RV32I memory stage: one data-memory transaction per instruction over a req/ack
// handshake, with byte-lane steering for stores and aligned, extended load writeback.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FAULT} state_e;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e          state_q, state_d;
  logic [31:0]     ea_q, ea_d;
  logic [2:0]      funct3_q;
  logic            is_store_q;
  logic [4:0]      rd_q;
  logic [31:0]     store_data_q;
  logic [31:0]     rdata_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            capture;
  logic            f3_legal;
  logic            misalign;
  logic            timeout_hit;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_value;

  assign ea_d    = base + offset;
  assign capture = (state_q == S_IDLE) && start;
  assign cnt_d   = (state_q == S_REQ) ? cnt_q + 1'b1 : '0;

  // Stores only have byte/half/word; loads add the unsigned byte/half forms.
  assign f3_legal = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                             : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misalign = ((funct3[1:0] == 2'b01) && ea_d[0]) ||
                    ((funct3[1:0] == 2'b10) && (ea_d[1:0] != 2'b00));

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q         <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      rd_q         <= '0;
      store_data_q <= '0;
      rdata_q      <= '0;
    end else begin
      if (capture) begin
        ea_q         <= ea_d;
        funct3_q     <= funct3;
        is_store_q   <= is_store;
        rd_q         <= rd;
        store_data_q <= store_data;
      end
      if ((state_q == S_REQ) && mem_ack) rdata_q <= mem_rdata;
    end
  end

  // NOTE: each combinational block assigns a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (!f3_legal || misalign) ? S_FAULT : S_REQ;
      S_REQ:   if (mem_ack) state_d = S_RESP;
               else if (timeout_hit) state_d = S_FAULT;
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_byte = rdata_q[{ea_q[1:0], 3'b000} +: 8];
  assign ld_half = ea_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ld_value = rdata_q;
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = rdata_q;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_RESP) || (state_q == S_FAULT);
    fault     = (state_q == S_FAULT);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    if (state_q == S_REQ) begin
      mem_req  = 1'b1;
      mem_we   = is_store_q;
      mem_addr = {ea_q[31:2], 2'b00};
      mem_be   = 4'b1111;
      if (is_store_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << ea_q[1:0];
            mem_wdata = {4{store_data_q[7:0]}};
          end
          2'b01: begin
            mem_be    = ea_q[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{store_data_q[15:0]}};
          end
          default: mem_wdata = store_data_q;
        endcase
      end
    end
    if (state_q == S_RESP) begin
      wb_rd = rd_q;
      if (!is_store_q) begin
        wb_en   = (rd_q != 5'd0);
        wb_data = ld_value;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and randomized loads/stores
// compared cycle by cycle against a byte-arithmetic reference model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        fault;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .rd         (rd),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, lane = ea mod 4, data moved by shifting whole bytes.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] ea,
                                input logic [31:0] sd, input logic [31:0] rdata,
                                output logic flt, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int size;
    int lane;
    logic legal;
    logic [31:0] tmp;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    flt   = !legal || ((ea % size) != 0);
    lane  = int'(ea % 4);
    be    = st ? 4'(((1 << size) - 1) << lane) : 4'hF;
    wd    = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
    tmp   = rdata >> (8 * lane);
    if (size == 1) begin
      tmp = tmp & 32'hFF;
      if (!f3[2] && tmp[7]) tmp = tmp | 32'hFFFF_FF00;
    end else if (size == 2) begin
      tmp = tmp & 32'hFFFF;
      if (!f3[2] && tmp[15]) tmp = tmp | 32'hFFFF_0000;
    end
    ld = tmp;
  endfunction

  // Drives junk on the issue port while the unit is busy; it must be ignored.
  task automatic drive_junk();
    start      = 1'b1;
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    base       = $urandom;
    offset     = $urandom;
    store_data = $urandom;
    rd         = 5'($urandom);
  endtask

  // One instruction: enters at the IDLE cycle, returns at the negedge of the done cycle.
  // delay = REQ cycles before ack; delay >= TO means no ack at all.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [31:0] off, input logic [31:0] sd, input logic [4:0] r,
                        input int delay, input logic [31:0] rdata);
    logic [31:0] ea;
    logic        flt;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    int          n_req;
    ea = b + off;
    model(st, f3, ea, sd, rdata, flt, be, wd, ld);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_req", mem_req, 0);
    start = 1'b1; is_store = st; funct3 = f3; base = b; offset = off;
    store_data = sd; rd = r;
    @(negedge clk);
    if (flt) begin
      check("flt_done", done, 1);
      check("flt_fault", fault, 1);
      check("flt_req", mem_req, 0);
      check("flt_wben", wb_en, 0);
      check("flt_wbrd", wb_rd, 0);
      drive_junk();
      return;
    end
    n_req = (delay >= TO) ? TO : delay + 1;
    for (int k = 0; k < n_req; k++) begin
      check("req_req", mem_req, 1);
      check("req_busy", busy, 1);
      check("req_done", done, 0);
      check("req_we", mem_we, st);
      check("req_addr", mem_addr, {ea[31:2], 2'b00});
      check("req_be", mem_be, be);
      check("req_wdata", mem_wdata, st ? wd : 32'h0);
      check("req_wben", wb_en, 0);
      drive_junk();
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? rdata : $urandom;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("end_done", done, 1);
    check("end_req", mem_req, 0);
    check("end_busy", busy, 1);
    if (delay >= TO) begin
      check("to_fault", fault, 1);
      check("to_wben", wb_en, 0);
    end else begin
      check("resp_fault", fault, 0);
      check("resp_wben", wb_en, (!st && r != 5'd0));
      check("resp_wbrd", wb_rd, r);
      check("resp_wbdata", wb_data, st ? 32'h0 : ld);
    end
    drive_junk();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; base = '0; offset = '0;
    store_data = '0; rd = '0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_wben", wb_en, 0);
    check("rst_wbrd", wb_rd, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(0, 3'b010, 32'hFC,  32'd4, 32'h0,        5'd5,  0, 32'hDEADBEEF);
    run_op(0, 3'b000, 32'h200, 32'd3, 32'h0,        5'd7,  0, 32'h80F17F00);
    run_op(0, 3'b100, 32'h200, 32'd3, 32'h0,        5'd7,  1, 32'h80F17F00);
    run_op(0, 3'b001, 32'h200, 32'd2, 32'h0,        5'd8,  0, 32'h80F17F00);
    run_op(0, 3'b101, 32'h202, 32'd0, 32'h0,        5'd9,  2, 32'h80F17F00);
    run_op(1, 3'b000, 32'h300, 32'd1, 32'h123456AB, 5'd3,  0, 32'h0);
    run_op(1, 3'b001, 32'h300, 32'd2, 32'h123456AB, 5'd3,  0, 32'h0);
    run_op(1, 3'b010, 32'h400, 32'hFFFF_FFFC, 32'hCAFEF00D, 5'd1, 0, 32'h0);
    run_op(0, 3'b010, 32'h100, 32'd2, 32'h0,        5'd4,  0, 32'h0);
    run_op(0, 3'b011, 32'h100, 32'd0, 32'h0,        5'd4,  0, 32'h0);
    run_op(1, 3'b100, 32'h100, 32'd0, 32'h0,        5'd4,  0, 32'h0);
    run_op(1, 3'b001, 32'h101, 32'd0, 32'h0,        5'd4,  0, 32'h0);
    run_op(0, 3'b010, 32'h100, 32'd0, 32'h0,        5'd0,  0, 32'h12345678);
    run_op(0, 3'b010, 32'h500, 32'd0, 32'h0,        5'd6,  5, 32'hA5A5_5A5A);
    run_op(0, 3'b001, 32'h600, 32'd2, 32'h0,        5'd6, TO - 1, 32'h7FFF_0001);
    run_op(1, 3'b010, 32'h700, 32'd0, 32'h11223344, 5'd2, 99, 32'h0);
    run_op(0, 3'b010, 32'h700, 32'd0, 32'h0,        5'd2, TO, 32'h0);

    // Asynchronous reset in the middle of REQ, then a stray ack.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h800; offset = 32'd0; rd = 5'd10;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_wben", wb_en, 0);
    check("late_ack_busy", busy, 0);
    check("late_ack_done", done, 0);
    run_op(0, 3'b010, 32'h800, 32'd4, 32'h0, 5'd11, 0, 32'h0BAD_F00D);

    // Randomized mix, biased toward mostly-legal accesses.
    for (int n = 0; n < 60; n++) begin
      logic        st;
      logic [2:0]  f3;
      int          dly;
      st  = 1'($urandom);
      f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
            (st ? 3'($urandom_range(0, 2)) : 3'({$urandom_range(0, 1), 2'($urandom_range(0, 2))}));
      dly = ($urandom_range(0, 9) == 0) ? $urandom_range(4, TO + 2) : $urandom_range(0, 3);
      run_op(st, f3, $urandom, 32'($urandom_range(0, 15)), $urandom, 5'($urandom),
             dly, $urandom);
    end

    @(negedge clk);
    start = 1'b0;
    check("final_idle_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("final_busy", busy, 0);
    check("final_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the RV32I core; sits directly downstream of the register file.
- Takes the base register value and the store-data register value read from the register file, plus the sign-extended immediate.
- Runs one data-memory transaction per instruction over a req/ack handshake. Supports LB/LH/LW/LBU/LHU and SB/SH/SW.
- Returns aligned, extended load data with a write enable and destination index that drive the register-file write port directly.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of REQ-state cycles to wait for mem_ack before faulting. 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue one memory instruction; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign field
- base  in  32  rs1 value from register file
- offset  in  32  sign-extended immediate
- store_data  in  32  rs2 value from register file
- rd  in  5  load destination index
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse, coincident with done, on misalignment, illegal funct3 or timeout
- wb_en  out  1  register-file write enable
- wb_rd  out  5  register-file destination
- wb_data  out  32  register-file write data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address; bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge

Behaviour:
- Reset: async, active-high. State goes to IDLE and all outputs go to 0 immediately. An in-flight mem_req drops without waiting for ack, and any ack arriving afterwards is ignored.
- Start capture: in IDLE with start=1, the unit computes ea = base + offset (mod 2^32). It registers ea, funct3, is_store, rd and store_data. start in any other state is ignored.
- Legal funct3 for loads: 000 (LB), 001 (LH), 010 (LW), 100 (LBU), 101 (LHU).
- Legal funct3 for stores: 000 (SB), 001 (SH), 010 (SW).
- Misalignment: halfword with ea[0]=1, or word with ea[1:0]!=0.
- Any illegal funct3 or misalignment sends the unit to FAULT. Otherwise it goes to REQ.
- State machine:
  - IDLE -> REQ or FAULT on start.
  - REQ: mem_req=1 and address/data/be held stable. mem_ack=1 goes to RESP. Timeout goes to FAULT.
  - RESP: lasts one cycle. done=1. For loads, wb_en=1 unless rd=0. Then go to IDLE.
  - FAULT: lasts one cycle. done=1, fault=1, wb_en=0, no memory access. Then go to IDLE.
- Latency: with ack in the first REQ cycle, done appears 2 cycles after the start cycle. Each cycle of ack delay adds one cycle.
- Back-to-back: a new start is accepted in the IDLE cycle that follows RESP or FAULT.
- Memory side:
  - mem_addr = {ea[31:2], 2'b00}; mem_we = is_store.
  - Loads use mem_be=1111.
  - SB: mem_be = 0001 << ea[1:0]; mem_wdata = store_data[7:0] replicated ×4.
  - SH: mem_be = ea[1] ? 1100 : 0011; mem_wdata = store_data[15:0] replicated ×2.
  - SW: mem_be = 1111; mem_wdata = store_data.
- Load data: mem_rdata is registered in the ack cycle, and wb_data is presented in RESP.
  - LB/LBU select byte lane ea[1:0]. LH/LHU select half ea[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes mem_rdata through.
- Writeback: wb_rd = captured rd during RESP and 0 otherwise.
  - wb_data is 0 outside RESP, and 0 during RESP for stores.
  - Stores never assert wb_en.
- Timeout: a counter resets on REQ entry. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES REQ cycles without ack, mem_req drops and the unit enters FAULT. An ack arriving in the same cycle the limit is reached wins, and the unit goes to RESP.
- mem_ack outside REQ is ignored.

Test Plan:
- Load word: memory holds 0xDEADBEEF at 0x100. LW with base=0xFC, offset=4, rd=5, ack in first REQ cycle -> mem_addr=0x100, mem_be=1111. done, wb_en=1, wb_rd=5, wb_data=0xDEADBEEF, 2 cycles after start.
- Sign/zero extension: mem_rdata=0x80F17F00 at ea=0x203. LB -> wb_data=0xFFFFFF80. LBU -> 0x00000080. At ea=0x202, LH -> 0xFFFF80F1 and LHU -> 0x000080F1.
- Stores: SB with ea=0x301, store_data=0x123456AB -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1, wb_en=0. SH with ea=0x302 -> mem_be=1100, mem_wdata=0x56AB56AB.
- Faults: LW at ea=0x102 -> fault+done pulse 1 cycle after start, mem_req never asserted. Load with funct3=011 -> same. LW with rd=0 -> done, wb_en=0.
- Handshake stall and timeout: ack delayed 5 cycles -> mem_req and address stay stable 5 cycles, done on cycle 7. With TIMEOUT_CYCLES=16 and no ack -> fault after 16 REQ cycles, mem_req=0 from the next cycle. start pulsed while busy -> ignored.
- Reset mid-REQ: assert rst asynchronously -> mem_req, busy and done are 0 immediately. A late ack after reset release causes no writeback, and the next start proceeds normally.
